// File: rtl/cordic_pkg.sv
// Shared constants and the in-flight tag type for the CORDIC round-robin scheduler.
// Optional quadrant folding is selected with the CORDIC_QUAD_FOLD_EN macro.
package cordic_pkg;

    localparam logic signed [31:0] ONE_Q16  = 32'sd65536;
    localparam logic signed [31:0] PI_Q16   = 32'sd205887;
    localparam logic signed [31:0] PI_2_Q16 = 32'sd102944;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
`ifdef CORDIC_QUAD_FOLD_EN
        logic                neg;
`endif
    } tag_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter: the priority pointer register plus a combinational one-hot grant.
// The search starts one past the last granted index and wraps modulo N_REQ.
module cordic_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        if (!halt) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = ID_W'((int'(ptr_reg) + k) % N_REQ);
                if (!grant_any && req_valid[idx]) begin
                    grant_any  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_id   = idx;
                end
            end
        end
    end

    // Pointer resets to the last index so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= ID_W'(N_REQ - 1);
        end else if (grant_any) begin
            ptr_reg <= grant_id;
        end
    end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one pipelined CORDIC rotation core among N_REQ requesters; a tag line matched
// to the core latency routes each result back. CORDIC_QUAD_FOLD_EN enables operand folding.
module cordic_rr_scheduler
    import cordic_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int DATA_W  = 32,
    parameter  int LATENCY = 16,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    halt,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_x0,
    input  logic [N_REQ*DATA_W-1:0] req_y0,
    input  logic [N_REQ*DATA_W-1:0] req_z0,
    output logic [DATA_W-1:0]       core_x0,
    output logic [DATA_W-1:0]       core_y0,
    output logic [DATA_W-1:0]       core_z0,
    input  logic [DATA_W-1:0]       core_x,
    input  logic [DATA_W-1:0]       core_y,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_x,
    output logic [DATA_W-1:0]       rsp_y,
    output logic                    busy
);

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;

    cordic_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .req_valid (req_valid),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign req_ready = grant;

    logic [DATA_W-1:0] x_slice [N_REQ];
    logic [DATA_W-1:0] y_slice [N_REQ];
    logic [DATA_W-1:0] z_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign x_slice[gi] = req_x0[gi*DATA_W +: DATA_W];
        assign y_slice[gi] = req_y0[gi*DATA_W +: DATA_W];
        assign z_slice[gi] = req_z0[gi*DATA_W +: DATA_W];
    end

    logic [DATA_W-1:0] z_sel;
    logic [DATA_W-1:0] z_issue;
    tag_t              tag_in;

    assign z_sel = z_slice[grant_id];

`ifdef CORDIC_QUAD_FOLD_EN
    localparam logic signed [DATA_W-1:0] PI_D       = DATA_W'(PI_Q16);
    localparam logic signed [DATA_W-1:0] PI_2_D     = DATA_W'(PI_2_Q16);
    localparam logic signed [DATA_W-1:0] NEG_PI_2_D = -PI_2_D;

    logic neg_issue;

    // Rotating by z-pi and negating the result equals rotating by z.
    always_comb begin
        z_issue   = z_sel;
        neg_issue = 1'b0;
        if ($signed(z_sel) > PI_2_D) begin
            z_issue   = z_sel - PI_D;
            neg_issue = 1'b1;
        end else if ($signed(z_sel) < NEG_PI_2_D) begin
            z_issue   = z_sel + PI_D;
            neg_issue = 1'b1;
        end
    end
`else
    assign z_issue = z_sel;
`endif

    always_comb begin
        tag_in       = '0;
        tag_in.valid = grant_any;
        tag_in.id    = TAG_ID_W'(grant_id);
`ifdef CORDIC_QUAD_FOLD_EN
        tag_in.neg   = neg_issue;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_x0 <= '0;
            core_y0 <= '0;
            core_z0 <= '0;
        end else if (grant_any) begin
            core_x0 <= x_slice[grant_id];
            core_y0 <= y_slice[grant_id];
            core_z0 <= z_issue;
        end
    end

    // Stage 0 lines up with the core input register, stage LATENCY with core_x/core_y.
    tag_t tag_reg [LATENCY+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            tag_reg[0] <= tag_in;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    logic [LATENCY:0] tag_valid;

    for (genvar gi = 0; gi <= LATENCY; gi++) begin : g_busy
        assign tag_valid[gi] = tag_reg[gi].valid;
    end

    assign busy = |tag_valid;

    tag_t             tag_last;
    logic [N_REQ-1:0] rsp_hit;
    logic [DATA_W-1:0] res_x;
    logic [DATA_W-1:0] res_y;

    assign tag_last = tag_reg[LATENCY];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hit
        assign rsp_hit[gi] = tag_last.valid && (tag_last.id == TAG_ID_W'(gi));
    end

`ifdef CORDIC_QUAD_FOLD_EN
    assign res_x = tag_last.neg ? -core_x : core_x;
    assign res_y = tag_last.neg ? -core_y : core_y;
`else
    assign res_x = core_x;
    assign res_y = core_y;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_x     <= '0;
            rsp_y     <= '0;
        end else begin
            rsp_valid <= rsp_hit;
            if (tag_last.valid) begin
                rsp_id <= ID_W'(tag_last.id);
                rsp_x  <= res_x;
                rsp_y  <= res_y;
            end
        end
    end

endmodule
